multi_tick_gen: RTL
===================

// Module: multi_tick_gen
// PURPOSE
//   Multi-channel programmable tick generator; successor to the single-channel fixed-ratio gen_tick.
//   NUM_CH independent channels, each with a runtime-programmable divisor, a square/pulse mode,
//   an enable and a phase restart. Sits beside the system clock and feeds timers, LED and scan logic.
// PARAMETERS
//   NUM_CH       4    number of tick channels (>=1)
//   CNT_W        16   divisor / counter width in bits
//   DEFAULT_DIV  2    divisor loaded into every channel at reset (2 .. 2^CNT_W-1)
//   CH_W (localparam) = (NUM_CH>1) ? $clog2(NUM_CH) : 1
// PORTS
//   clk        in   1       system clock; all state updates on its rising edge
//   reset      in   1       asynchronous, active-low reset
//   enable     in   NUM_CH  per-channel count enable
//   restart    in   NUM_CH  per-channel synchronous phase restart
//   cfg_wr     in   1       config write strobe, one cycle
//   cfg_ch     in   CH_W    channel to configure
//   cfg_div    in   CNT_W   divisor D = clk cycles per tick period; valid range D>=2
//   cfg_mode   in   1       0 = square wave, 1 = single-cycle pulse
//   cfg_ack    out  1       1-cycle pulse, the cycle after any cfg_wr
//   cfg_err    out  1       1-cycle pulse with cfg_ack when the write was rejected
//   tick       out  NUM_CH  per-channel tick output, registered
//   tick_rise  out  NUM_CH  per-channel 1-cycle strobe on each 0->1 transition of tick, registered
// BEHAVIOUR
//   Reset (reset=0, async): per channel cnt=0, div=DEFAULT_DIV, mode=0; tick=0, tick_rise=0,
//     cfg_ack=0, cfg_err=0. Takes effect immediately, mid-operation included.
//   Per-channel state: cnt[CNT_W], div[CNT_W], mode. All outputs are registers, no comb paths.
//   Output function f(c): square -> (c >= D - floor(D/2)); pulse -> (c == D-1).
//   Per-channel priority at each edge, highest first:
//     1. Accepted cfg_wr to this channel: div<=cfg_div, mode<=cfg_mode, cnt<=0, tick<=0, tick_rise<=0.
//     2. restart[i]=1: cnt<=0, tick<=0, tick_rise<=0; div and mode kept.
//     3. enable[i]=1: cnt_n = (cnt==div-1) ? 0 : cnt+1; cnt<=cnt_n; tick<=f(cnt_n);
//        tick_rise <= f(cnt_n) & ~tick.
//     4. Otherwise: cnt and tick hold (phase frozen), tick_rise<=0.
//   Square mode: period D; high floor(D/2) cycles, low ceil(D/2) cycles.
//     First rise comes ceil(D/2) enabled edges after cnt=0. D=2 toggles tick every cycle.
//   Pulse mode: tick high exactly 1 of every D enabled cycles, first at edge D-1 after cnt=0.
//     tick_rise==tick every cycle.
//   Config accept: cfg_wr=1 && cfg_div>=2 && cfg_ch<NUM_CH.
//     Rejected writes change no channel state; they pulse cfg_ack=1 and cfg_err=1.
//     Accepted writes pulse cfg_ack=1 with cfg_err=0, one cycle after the strobe.
//   Writes may arrive back-to-back every cycle, each acked independently.
//   A write to channel i leaves every other channel untouched.
//   Divisor change always restarts phase; partial periods are never emitted.
//   Counter never exceeds div-1 and wraps to 0. No arithmetic overflow: D <= 2^CNT_W-1.
// TESTING
//   T1 reset, enable=all 1, no cfg, 1000 cycles -> each tick toggles every cycle,
//      500 high samples, 500 rises.
//   T2 cfg ch0 D=50, ch1 D=20, ch2 D=2 (square), 1000 enabled cycles ->
//      high counts 500/500/500, rises 20/50/500.
//   T3 ch3 D=10 pulse, 1000 cycles -> 100 single-cycle ticks, first 9 edges after write,
//      tick_rise==tick throughout.
//   T4 ch0 D=5 square, 1000 cycles -> pattern low,low,low,high,high repeating;
//      400 high, 200 rises.
//   T5 cfg_div=0 and 1, plus cfg_ch=3 on a NUM_CH=3 instance -> cfg_ack=1, cfg_err=1,
//      outputs and periods unchanged; a valid write next cycle -> ack with err=0.
//   T6 enable low 7 cycles mid-period -> tick/cnt frozen, period resumes.
//      restart on ch0+ch1 with equal D -> identical ticks afterwards.
//      reset low mid-run -> all outputs 0 immediately, DEFAULT_DIV restored.

Source files
------------

// File: rtl/multi_tick_gen_if.sv
// Control/status bundle for multi_tick_gen: per-channel enable/restart, the
// configuration write port with its ack/err response, and the tick outputs.
interface multi_tick_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] restart;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_mode;
  logic              cfg_ack;
  logic              cfg_err;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] tick_rise;

  modport master (
    output enable, restart, cfg_wr, cfg_ch, cfg_div, cfg_mode,
    input  cfg_ack, cfg_err, tick, tick_rise
  );

  modport slave (
    input  enable, restart, cfg_wr, cfg_ch, cfg_div, cfg_mode,
    output cfg_ack, cfg_err, tick, tick_rise
  );
endinterface

// File: rtl/multi_tick_gen.sv
// Multi-channel programmable tick generator: per-channel divisor, square/pulse
// mode, enable and phase restart; every output is a register.
module multi_tick_gen #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic            clk,
  input  logic            reset,
  multi_tick_gen_if.slave bus
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0]  cnt   [NUM_CH];
  logic [CNT_W-1:0]  div   [NUM_CH];
  logic [CNT_W-1:0]  cnt_n [NUM_CH];
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] f_n;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] rise_q;
  logic              ack_q;
  logic              err_q;
  logic              cfg_ok;

  assign cfg_ok = bus.cfg_wr && (bus.cfg_div >= TWO) && (32'(bus.cfg_ch) < NUM_CH);

  // Next count and the output level it maps to, evaluated ahead of the edge
  // so tick registers the value belonging to the new count.
  always_comb begin
    f_n = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_n[i] = (cnt[i] == div[i] - ONE) ? '0 : cnt[i] + ONE;
      if (mode[i])
        f_n[i] = (cnt_n[i] == div[i] - ONE);
      else
        f_n[i] = (cnt_n[i] >= div[i] - (div[i] >> 1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        div[i] <= CNT_W'(DEFAULT_DIV);
      end
      mode   <= '0;
      tick_q <= '0;
      rise_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ack_q <= bus.cfg_wr;
      err_q <= bus.cfg_wr & ~cfg_ok;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cfg_ok && (32'(bus.cfg_ch) == i)) begin
          div[i]    <= bus.cfg_div;
          mode[i]   <= bus.cfg_mode;
          cnt[i]    <= '0;
          tick_q[i] <= 1'b0;
          rise_q[i] <= 1'b0;
        end else if (bus.restart[i]) begin
          cnt[i]    <= '0;
          tick_q[i] <= 1'b0;
          rise_q[i] <= 1'b0;
        end else if (bus.enable[i]) begin
          cnt[i]    <= cnt_n[i];
          tick_q[i] <= f_n[i];
          rise_q[i] <= f_n[i] & ~tick_q[i];
        end else begin
          rise_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.tick      = tick_q;
  assign bus.tick_rise = rise_q;
  assign bus.cfg_ack   = ack_q;
  assign bus.cfg_err   = err_q;
endmodule
